// File: rtl/pwm_timebase_ctrl_if.sv
// Config and timebase bundle between the register file (master) and the PWM timebase (slave).
interface pwm_timebase_ctrl_if #(
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 8,
    parameter int FUNC_W = 8
);
    logic              cnt_en;
    logic              cnt_clr;
    logic              upnotdown;
    logic [PSC_W-1:0]  prescale;
    logic              cfg_load;
    logic [CNT_W-1:0]  period_in;
    logic [CNT_W-1:0]  compare1_in;
    logic [CNT_W-1:0]  compare2_in;
    logic [FUNC_W-1:0] functions_in;
    logic              one_shot;
    logic [CNT_W-1:0]  count_val;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  compare1;
    logic [CNT_W-1:0]  compare2;
    logic [FUNC_W-1:0] functions;
    logic              pwm_en;
    logic              period_done;
    logic              cfg_pending;

    modport master (
        output cnt_en, cnt_clr, upnotdown, prescale, cfg_load, period_in,
               compare1_in, compare2_in, functions_in, one_shot,
        input  count_val, period, compare1, compare2, functions, pwm_en,
               period_done, cfg_pending
    );

    modport slave (
        input  cnt_en, cnt_clr, upnotdown, prescale, cfg_load, period_in,
               compare1_in, compare2_in, functions_in, one_shot,
        output count_val, period, compare1, compare2, functions, pwm_en,
               period_done, cfg_pending
    );
endinterface

// File: rtl/pwm_timebase_ctrl.sv
// PWM timebase: prescaled up/down counter with double-buffered period/compare/functions.
// Optional one-shot mode is built when PWM_ONESHOT_EN is defined.
module pwm_timebase_ctrl #(
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 8,
    parameter int FUNC_W = 8
) (
    input logic                clk,
    input logic                rst,
    pwm_timebase_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [PSC_W-1:0]  psc_cnt;
    logic [CNT_W-1:0]  act_period, act_cmp1, act_cmp2;
    logic [FUNC_W-1:0] act_func;
    logic [PSC_W-1:0]  act_psc;
    logic              act_up;
    logic [CNT_W-1:0]  stg_period, stg_cmp1, stg_cmp2;
    logic [FUNC_W-1:0] stg_func;
    logic [PSC_W-1:0]  stg_psc;
    logic              stg_up;
    logic              pending, done_q, pwm_en_q;
    logic              tick, wrap, apply, dir_chg, os_stop, os_hold;

`ifdef PWM_ONESHOT_EN
    logic os_hold_q;

    // Once a one-shot period completes, hold in IDLE until cnt_en is dropped.
    always_ff @(posedge clk) begin
        if (rst)
            os_hold_q <= 1'b0;
        else if (!bus.cnt_en)
            os_hold_q <= 1'b0;
        else if (os_stop)
            os_hold_q <= 1'b1;
    end

    assign os_hold = os_hold_q;
    assign os_stop = wrap && bus.one_shot;
`else
    logic unused_one_shot;

    assign unused_one_shot = bus.one_shot;
    assign os_hold         = 1'b0;
    assign os_stop         = 1'b0;
`endif

    always_comb begin
        tick    = (state == RUN) && (psc_cnt == act_psc);
        // Up mode wraps on >= so a shrunk period never lets the count run away.
        wrap    = tick && !bus.cnt_clr && (act_up ? (cnt >= act_period) : (cnt == '0));
        apply   = pending && !bus.cnt_clr && (wrap || (state == IDLE));
        dir_chg = apply && (stg_up != act_up);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.cnt_en && !os_hold) state_nx = RUN;
            RUN:  if (!bus.cnt_en || os_stop) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            psc_cnt    <= '0;
            act_period <= '0;
            act_cmp1   <= '0;
            act_cmp2   <= '0;
            act_func   <= '0;
            act_psc    <= '0;
            act_up     <= 1'b1;
            stg_period <= '0;
            stg_cmp1   <= '0;
            stg_cmp2   <= '0;
            stg_func   <= '0;
            stg_psc    <= '0;
            stg_up     <= 1'b1;
            pending    <= 1'b0;
            done_q     <= 1'b0;
            pwm_en_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            pwm_en_q <= (state == RUN);
            done_q   <= wrap;

            if (bus.cfg_load) begin
                stg_period <= bus.period_in;
                stg_cmp1   <= bus.compare1_in;
                stg_cmp2   <= bus.compare2_in;
                stg_func   <= bus.functions_in;
                stg_psc    <= bus.prescale;
                stg_up     <= bus.upnotdown;
            end

            // A load on the apply edge keeps the flag set for the freshly staged set.
            if (bus.cfg_load)
                pending <= 1'b1;
            else if (apply)
                pending <= 1'b0;

            if (apply) begin
                act_period <= stg_period;
                act_cmp1   <= stg_cmp1;
                act_cmp2   <= stg_cmp2;
                act_func   <= stg_func;
                act_psc    <= stg_psc;
                act_up     <= stg_up;
            end

            if (bus.cnt_clr || (state != RUN) || tick)
                psc_cnt <= '0;
            else
                psc_cnt <= psc_cnt + 1'b1;

            if (bus.cnt_clr)
                cnt <= act_up ? '0 : act_period;
            else if (dir_chg)
                cnt <= stg_up ? '0 : stg_period;
            else if (tick) begin
                if (act_up)
                    cnt <= wrap ? '0 : cnt + 1'b1;
                else if (wrap)
                    cnt <= apply ? stg_period : act_period;
                else
                    cnt <= cnt - 1'b1;
            end
        end
    end

    assign bus.count_val   = cnt;
    assign bus.period      = act_period;
    assign bus.compare1    = act_cmp1;
    assign bus.compare2    = act_cmp2;
    assign bus.functions   = act_func;
    assign bus.pwm_en      = pwm_en_q;
    assign bus.period_done = done_q;
    assign bus.cfg_pending = pending;
endmodule

// File: tb/tb_pwm_timebase_ctrl.sv
// Directed bench for pwm_timebase_ctrl; one task per scenario, inline checks.
module tb_pwm_timebase_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pwm_timebase_ctrl_if bus ();

    pwm_timebase_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.cnt_en   = 1'b0;
        bus.cnt_clr  = 1'b0;
        bus.cfg_load = 1'b0;
        bus.one_shot = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic load(input logic [15:0] p, input logic [15:0] c1, input logic [15:0] c2,
                        input logic [7:0] f, input logic [7:0] psc, input logic up);
        bus.period_in    = p;
        bus.compare1_in  = c1;
        bus.compare2_in  = c2;
        bus.functions_in = f;
        bus.prescale     = psc;
        bus.upnotdown    = up;
        bus.cfg_load     = 1'b1;
        cyc();
        bus.cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.count_val, bus.period, bus.compare1, bus.compare2} !== 64'd0) begin
            $display("FAIL reset_values got=%h exp=0", {bus.count_val, bus.period, bus.compare1, bus.compare2});
            failures++;
        end
        checks++;
        if ({bus.functions, bus.pwm_en, bus.period_done, bus.cfg_pending} !== 11'd0) begin
            $display("FAIL reset_flags got=%h exp=0", {bus.functions, bus.pwm_en, bus.period_done, bus.cfg_pending});
            failures++;
        end
    endtask

    task automatic test_up_count();
        int exp_c[7] = '{0, 1, 2, 3, 4, 0, 1};
        int exp_d[7] = '{0, 0, 0, 0, 0, 1, 0};
        do_reset();
        load(16'd4, 16'd1, 16'd3, 8'hA5, 8'd0, 1'b1);
        checks++;
        if ({bus.cfg_pending, bus.period} !== {1'b1, 16'd0}) begin
            $display("FAIL up_staged got=%h exp=%h", {bus.cfg_pending, bus.period}, {1'b1, 16'd0});
            failures++;
        end
        cyc();
        checks++;
        if ({bus.cfg_pending, bus.period, bus.compare1, bus.compare2, bus.functions} !==
            {1'b0, 16'd4, 16'd1, 16'd3, 8'hA5}) begin
            $display("FAIL up_idle_apply got=%h", {bus.cfg_pending, bus.period, bus.compare1, bus.compare2, bus.functions});
            failures++;
        end
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc();
            checks++;
            if ({bus.count_val, bus.period_done} !== {exp_c[i][15:0], exp_d[i][0]}) begin
                $display("FAIL up_seq[%0d] count=%0d done=%0d exp count=%0d done=%0d",
                         i, bus.count_val, bus.period_done, exp_c[i], exp_d[i]);
                failures++;
            end
        end
        checks++;
        if (bus.pwm_en !== 1'b1) begin
            $display("FAIL up_pwm_en got=%0d exp=1", bus.pwm_en);
            failures++;
        end
        bus.cnt_en = 1'b0;
        cyc();
        cyc();
        checks++;
        if ({bus.count_val, bus.pwm_en} !== {16'd2, 1'b0}) begin
            $display("FAIL up_stop count=%0d pwm_en=%0d exp count=2 pwm_en=0", bus.count_val, bus.pwm_en);
            failures++;
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        load(16'd9, 16'd4, 16'd5, 8'h11, 8'd0, 1'b1);
        cyc();
        bus.cnt_en = 1'b1;
        cyc();
        repeat (5) cyc();
        load(16'd3, 16'd1, 16'd1, 8'h22, 8'd0, 1'b1);
        cyc();
        checks++;
        if ({bus.count_val, bus.cfg_pending, bus.period} !== {16'd7, 1'b1, 16'd9}) begin
            $display("FAIL midrun_pre count=%0d pend=%0d period=%0d exp 7/1/9",
                     bus.count_val, bus.cfg_pending, bus.period);
            failures++;
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.cnt_en = 1'b0;
        checks++;
        if ({bus.count_val, bus.period, bus.compare1, bus.functions, bus.pwm_en, bus.period_done, bus.cfg_pending} !== 59'd0) begin
            $display("FAIL midrun_reset got=%h exp=0",
                     {bus.count_val, bus.period, bus.compare1, bus.functions, bus.pwm_en, bus.period_done, bus.cfg_pending});
            failures++;
        end
    endtask

    task automatic test_prescale_down();
        int exp_c[14] = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3, 3};
        do_reset();
        load(16'd3, 16'd0, 16'd0, 8'h00, 8'd2, 1'b0);
        cyc();
        checks++;
        if (bus.count_val !== 16'd3) begin
            $display("FAIL down_dir_apply count=%0d exp=3", bus.count_val);
            failures++;
        end
        bus.cnt_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            cyc();
            checks++;
            if ({bus.count_val, bus.period_done} !== {exp_c[i][15:0], (i == 12)}) begin
                $display("FAIL down_seq[%0d] count=%0d done=%0d exp count=%0d done=%0d",
                         i, bus.count_val, bus.period_done, exp_c[i], (i == 12));
                failures++;
            end
        end
    endtask

    task automatic test_shadow();
        do_reset();
        load(16'd9, 16'd7, 16'd8, 8'h01, 8'd0, 1'b1);
        cyc();
        bus.cnt_en = 1'b1;
        cyc();
        repeat (3) cyc();
        load(16'd5, 16'd2, 16'd3, 8'h02, 8'd0, 1'b1);
        checks++;
        if ({bus.count_val, bus.period, bus.compare1, bus.cfg_pending} !== {16'd4, 16'd9, 16'd7, 1'b1}) begin
            $display("FAIL shadow_hold count=%0d period=%0d cmp1=%0d pend=%0d exp 4/9/7/1",
                     bus.count_val, bus.period, bus.compare1, bus.cfg_pending);
            failures++;
        end
        repeat (5) cyc();
        checks++;
        if ({bus.count_val, bus.period, bus.cfg_pending} !== {16'd9, 16'd9, 1'b1}) begin
            $display("FAIL shadow_pre_wrap count=%0d period=%0d pend=%0d exp 9/9/1",
                     bus.count_val, bus.period, bus.cfg_pending);
            failures++;
        end
        cyc();
        checks++;
        if ({bus.count_val, bus.period_done, bus.period, bus.compare1, bus.compare2, bus.functions, bus.cfg_pending} !==
            {16'd0, 1'b1, 16'd5, 16'd2, 16'd3, 8'h02, 1'b0}) begin
            $display("FAIL shadow_apply got=%h",
                     {bus.count_val, bus.period_done, bus.period, bus.compare1, bus.compare2, bus.functions, bus.cfg_pending});
            failures++;
        end
        repeat (5) cyc();
        cyc();
        checks++;
        if ({bus.count_val, bus.period_done} !== {16'd0, 1'b1}) begin
            $display("FAIL shadow_new_period count=%0d done=%0d exp 0/1", bus.count_val, bus.period_done);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(16'd4, 16'd1, 16'd1, 8'h00, 8'd0, 1'b1);
        cyc();
        bus.cnt_en = 1'b1;
        cyc();
        load(16'd6, 16'd3, 16'd3, 8'h33, 8'd0, 1'b1);
        cyc();
        cyc();
        cyc();
        load(16'd8, 16'd5, 16'd5, 8'h55, 8'd0, 1'b1);
        checks++;
        if ({bus.count_val, bus.period_done, bus.period, bus.compare1, bus.functions, bus.cfg_pending} !==
            {16'd0, 1'b1, 16'd6, 16'd3, 8'h33, 1'b1}) begin
            $display("FAIL b2b_apply got=%h",
                     {bus.count_val, bus.period_done, bus.period, bus.compare1, bus.functions, bus.cfg_pending});
            failures++;
        end
        repeat (6) cyc();
        checks++;
        if ({bus.count_val, bus.period} !== {16'd6, 16'd6}) begin
            $display("FAIL b2b_count6 count=%0d period=%0d exp 6/6", bus.count_val, bus.period);
            failures++;
        end
        bus.cnt_clr = 1'b1;
        cyc();
        bus.cnt_clr = 1'b0;
        checks++;
        if ({bus.count_val, bus.period_done, bus.period, bus.cfg_pending} !== {16'd0, 1'b0, 16'd6, 1'b1}) begin
            $display("FAIL b2b_clr count=%0d done=%0d period=%0d pend=%0d exp 0/0/6/1",
                     bus.count_val, bus.period_done, bus.period, bus.cfg_pending);
            failures++;
        end
        cyc();
        checks++;
        if ({bus.count_val, bus.period} !== {16'd1, 16'd6}) begin
            $display("FAIL b2b_after_clr count=%0d period=%0d exp 1/6", bus.count_val, bus.period);
            failures++;
        end
    endtask

    task automatic test_boundaries();
        // period 0: count stays 0 and period_done fires on every tick
        do_reset();
        load(16'd0, 16'd0, 16'd0, 8'h00, 8'd0, 1'b1);
        cyc();
        bus.cnt_en = 1'b1;
        cyc();
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if ({bus.count_val, bus.period_done} !== {16'd0, 1'b1}) begin
                $display("FAIL period0[%0d] count=%0d done=%0d exp 0/1", i, bus.count_val, bus.period_done);
                failures++;
            end
        end
        // shrink period in IDLE below the held count; up mode wraps on next tick
        do_reset();
        load(16'd9, 16'd0, 16'd0, 8'h00, 8'd0, 1'b1);
        cyc();
        bus.cnt_en = 1'b1;
        cyc();
        repeat (6) cyc();
        bus.cnt_en = 1'b0;
        cyc();
        load(16'd3, 16'd0, 16'd0, 8'h00, 8'd0, 1'b1);
        cyc();
        checks++;
        if ({bus.count_val, bus.period} !== {16'd7, 16'd3}) begin
            $display("FAIL shrink_idle count=%0d period=%0d exp 7/3", bus.count_val, bus.period);
            failures++;
        end
        bus.cnt_en = 1'b1;
        cyc();
        cyc();
        checks++;
        if ({bus.count_val, bus.period_done} !== {16'd0, 1'b1}) begin
            $display("FAIL shrink_wrap count=%0d done=%0d exp 0/1", bus.count_val, bus.period_done);
            failures++;
        end
    endtask

`ifdef PWM_ONESHOT_EN
    task automatic test_oneshot();
        do_reset();
        load(16'd2, 16'd0, 16'd0, 8'h00, 8'd0, 1'b1);
        cyc();
        bus.one_shot = 1'b1;
        bus.cnt_en   = 1'b1;
        repeat (4) cyc();
        checks++;
        if ({bus.count_val, bus.period_done, bus.pwm_en} !== {16'd0, 1'b1, 1'b1}) begin
            $display("FAIL oneshot_wrap count=%0d done=%0d pwm_en=%0d exp 0/1/1",
                     bus.count_val, bus.period_done, bus.pwm_en);
            failures++;
        end
        cyc();
        cyc();
        checks++;
        if ({bus.count_val, bus.pwm_en} !== {16'd0, 1'b0}) begin
            $display("FAIL oneshot_stop count=%0d pwm_en=%0d exp 0/0", bus.count_val, bus.pwm_en);
            failures++;
        end
        bus.cnt_en = 1'b0;
        cyc();
        bus.cnt_en = 1'b1;
        cyc();
        cyc();
        checks++;
        if (bus.count_val !== 16'd1) begin
            $display("FAIL oneshot_restart count=%0d exp=1", bus.count_val);
            failures++;
        end
    endtask
`endif

    initial begin
        checks           = 0;
        failures         = 0;
        rst              = 1'b1;
        bus.cnt_en       = 1'b0;
        bus.cnt_clr      = 1'b0;
        bus.upnotdown    = 1'b1;
        bus.prescale     = '0;
        bus.cfg_load     = 1'b0;
        bus.period_in    = '0;
        bus.compare1_in  = '0;
        bus.compare2_in  = '0;
        bus.functions_in = '0;
        bus.one_shot     = 1'b0;
        test_reset();
        test_up_count();
        test_reset_midrun();
        test_prescale_down();
        test_shadow();
        test_back_to_back();
        test_boundaries();
`ifdef PWM_ONESHOT_EN
        test_oneshot();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pwm_timebase_ctrl.md
Name: pwm_timebase_ctrl

Overview:
Timebase and configuration sequencer for the PWM generator. Produces the free-running count value the generator compares against, applies a prescaler, and supports up or down counting. Double-buffers period/compare/functions so register writes take effect only at a period boundary, which prevents glitched PWM cycles. Sits between the register file (SPI-side config) and the PWM generator.

Parameters:
CNT_W, 16, width of counter, period and compare values
PSC_W, 8, width of prescaler setting
FUNC_W, 8, width of functions field

Ports:
clk  input  1  peripheral clock, single clock domain
rst  input  1  synchronous reset, active-high
cnt_en  input  1  counter enable from register file
cnt_clr  input  1  single-cycle soft clear of counter and prescaler
upnotdown  input  1  1 = count up, 0 = count down (buffered)
prescale  input  PSC_W  tick every prescale+1 clocks (buffered)
cfg_load  input  1  single-cycle strobe: capture *_in into staging regs
period_in  input  CNT_W  staged period
compare1_in  input  CNT_W  staged compare1
compare2_in  input  CNT_W  staged compare2
functions_in  input  FUNC_W  staged functions
one_shot  input  1  stop after one period (only with PWM_ONESHOT_EN)
count_val  output  CNT_W  current count to PWM generator
period  output  CNT_W  active period
compare1  output  CNT_W  active compare1
compare2  output  CNT_W  active compare2
functions  output  FUNC_W  active functions
pwm_en  output  1  gate to PWM generator; high while counter running
period_done  output  1  one-cycle pulse on wrap/reload
cfg_pending  output  1  staged config not yet applied

Behaviour:
- Reset (rst high at clk edge): all outputs and internal regs 0; direction reg = up; state IDLE.
- States: IDLE (cnt_en=0), RUN. IDLE->RUN when cnt_en=1; RUN->IDLE when cnt_en=0 (count_val held, prescaler cleared).
- pwm_en = registered (state==RUN).
- Prescaler: psc_cnt increments each clk in RUN; when psc_cnt==active prescale, tick asserts and psc_cnt->0. prescale=0 gives tick every clock.
- Up mode, on tick: if count_val==period then count_val<=0, period_done pulses same edge; else count_val+1.
- Down mode, on tick: if count_val==0 then count_val<=period, period_done pulses; else count_val-1.
- period==0: count_val stays 0 (up) / reloads 0 (down); period_done on every tick.
- count_val>period (after shrinking period): up mode wraps at next tick as if equal; down mode continues down normally.
- Staging: cfg_load captures period_in, compare1_in, compare2_in, functions_in, prescale, upnotdown; sets cfg_pending. Later cfg_load before apply overwrites staging (last write wins).
- Apply: staging->active at the edge where period_done pulses, or on the next clk while in IDLE; cfg_pending clears same edge. cfg_load coincident with apply: new values staged, cfg_pending remains 1, previous staging applied.
- Direction change on apply: counter restarts at 0 (up) or new period (down) on that edge instead of the normal wrap value.
- cnt_clr: highest priority after rst; count_val<=0 (up) or active period (down), psc_cnt<=0, no period_done, pending config not applied.
- Latency: cfg_load -> active outputs minimum 1 clk (IDLE); count_val changes 1 clk after tick condition.

Optional Feature:
PWM_ONESHOT_EN: when defined and one_shot=1 in RUN, the first period_done forces state to IDLE (pwm_en drops the next edge, count_val holds wrap value) until cnt_en is deasserted and reasserted. Without the macro, one_shot is ignored and the counter runs continuously.

Test Plan:
- Reset mid-run: count_val=7, rst=1 one cycle -> all outputs 0, state IDLE, cfg_pending=0.
- Up count: period=4, prescale=0, cnt_en=1 -> count_val 0,1,2,3,4,0; period_done pulses exactly on 4->0 edge.
- Prescaler/down: prescale=2, upnotdown=0, period=3 -> each value held 3 clks: 3,2,1,0,3; period_done on 0->3.
- Shadow update: running period=9, cfg_load with period_in=5, compare1_in=2 at count 3 -> outputs stay 9/old until wrap at 9, then period=5, compare1=2, cfg_pending 1->0 on that edge.
- Simultaneous cfg_load and period_done: old staging applied, new staging held, cfg_pending stays 1; cnt_clr at count 6 -> count_val 0 next clk, no period_done.
- PWM_ONESHOT_EN: one_shot=1, period=2 -> counts 0,1,2,0 then pwm_en=0, count_val holds 0; toggling cnt_en restarts.
